// File: rtl/axil_timer_pkg.sv
// Shared types and register offsets for the AXI4-Lite timer.
// Optional prescaler is enabled by defining AXIL_TIMER_PRESCALER_EN.
package axil_timer_pkg;

  localparam int unsigned OFF_CTRL     = 32'h00;
  localparam int unsigned OFF_STATUS   = 32'h04;
  localparam int unsigned OFF_CNT_LO   = 32'h08;
  localparam int unsigned OFF_CNT_HI   = 32'h0C;
  localparam int unsigned OFF_CMP_LO   = 32'h10;
  localparam int unsigned OFF_CMP_HI   = 32'h14;
  localparam int unsigned OFF_PRESCALE = 32'h18;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef struct packed {
    logic periodic;
    logic ie;
    logic en;
  } ctrl_t;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/axil_timer_core.sv
// Counter, compare, prescaler and sticky pending flag, driven by decoded write strobes.
// Prescaler is present only when AXIL_TIMER_PRESCALER_EN is defined.
module axil_timer_core
  import axil_timer_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] wdata,
  input  logic [31:0] wmask,
  input  logic        we_ctrl,
  input  logic        we_status,
  input  logic        we_cnt_lo,
  input  logic        we_cnt_hi,
  input  logic        we_cmp_lo,
  input  logic        we_cmp_hi,
  input  logic        we_prescale,
  output ctrl_t       ctrl,
  output logic        pending,
  output logic [63:0] cnt,
  output logic [63:0] cmp,
  output logic [15:0] prescale,
  output logic        irq
);

  logic tick;
  logic ge;
  logic ge_q;
  logic new_match;

`ifdef AXIL_TIMER_PRESCALER_EN
  logic [15:0] pcnt;

  assign tick = ctrl.en && (pcnt == prescale);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pcnt     <= '0;
      prescale <= '0;
    end else if (we_prescale) begin
      prescale <= (prescale & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
      pcnt     <= '0;
    end else if (ctrl.en) begin
      pcnt <= tick ? '0 : pcnt + 16'd1;
    end
  end
`else
  logic unused_prescale;

  assign tick            = ctrl.en;
  assign prescale        = '0;
  assign unused_prescale = we_prescale;
`endif

  // Pending sets on the rising edge of cnt>=cmp, so a W1C sticks while the count stays past compare.
  assign ge        = ctrl.en && (cnt >= cmp);
  assign new_match = ge && !ge_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl    <= '0;
      pending <= 1'b0;
      cnt     <= '0;
      cmp     <= '0;
      ge_q    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      ge_q <= ge;
      irq  <= pending & ctrl.ie;
      if (we_ctrl) ctrl <= ctrl_t'((ctrl & ~wmask[2:0]) | (wdata[2:0] & wmask[2:0]));
      if (we_cmp_lo) cmp[31:0] <= merge(cmp[31:0], wdata, wmask);
      if (we_cmp_hi) cmp[63:32] <= merge(cmp[63:32], wdata, wmask);
      if (we_cnt_lo || we_cnt_hi) begin
        if (we_cnt_lo) cnt[31:0] <= merge(cnt[31:0], wdata, wmask);
        if (we_cnt_hi) cnt[63:32] <= merge(cnt[63:32], wdata, wmask);
      end else if (ge && ctrl.periodic) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 64'd1;
      end
      if (new_match) pending <= 1'b1;
      else if (we_status && wmask[0] && wdata[0]) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_timer.sv
// AXI4-Lite slave front end for the 64-bit timer: write/read FSMs, decode and read mux.
// Define AXIL_TIMER_PRESCALER_EN to map the PRESCALE register at 0x18.
module axil_timer
  import axil_timer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    irq
);

  wstate_t wstate;
  rstate_t rstate;
  ctrl_t   ctrl;
  logic        pending;
  logic [63:0] cnt, cmp;
  logic [15:0] prescale;
  logic [31:0] shadow, wmask, rd_data;
  logic        aw_hs, ar_hs, w_ok, rd_ok;
  logic        we_ctrl, we_status, we_cnt_lo, we_cnt_hi, we_cmp_lo, we_cmp_hi, we_prescale;
  logic [ADDR_WIDTH-1:0] wa, ra;
  logic        unused_ok;

  assign unused_ok = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
  assign wa        = {awaddr[ADDR_WIDTH-1:2], 2'b00};
  assign ra        = {araddr[ADDR_WIDTH-1:2], 2'b00};

  assign aw_hs   = aresetn && (wstate == W_IDLE) && awvalid && wvalid;
  assign awready = aw_hs;
  assign wready  = aw_hs;
  assign ar_hs   = arready && arvalid;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) wmask[8*i +: 8] = {8{wstrb[i]}};
  end

  always_comb begin
    we_ctrl = 1'b0; we_status = 1'b0; we_cnt_lo = 1'b0; we_cnt_hi = 1'b0;
    we_cmp_lo = 1'b0; we_cmp_hi = 1'b0; we_prescale = 1'b0;
    w_ok = 1'b1;
    case (wa)
      ADDR_WIDTH'(OFF_CTRL):     we_ctrl   = aw_hs;
      ADDR_WIDTH'(OFF_STATUS):   we_status = aw_hs;
      ADDR_WIDTH'(OFF_CNT_LO):   we_cnt_lo = aw_hs;
      ADDR_WIDTH'(OFF_CNT_HI):   we_cnt_hi = aw_hs;
      ADDR_WIDTH'(OFF_CMP_LO):   we_cmp_lo = aw_hs;
      ADDR_WIDTH'(OFF_CMP_HI):   we_cmp_hi = aw_hs;
`ifdef AXIL_TIMER_PRESCALER_EN
      ADDR_WIDTH'(OFF_PRESCALE): we_prescale = aw_hs;
`endif
      default:                   w_ok = 1'b0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b1;
    case (ra)
      ADDR_WIDTH'(OFF_CTRL):     rd_data = 32'(ctrl);
      ADDR_WIDTH'(OFF_STATUS):   rd_data = {31'b0, pending};
      ADDR_WIDTH'(OFF_CNT_LO):   rd_data = cnt[31:0];
      ADDR_WIDTH'(OFF_CNT_HI):   rd_data = shadow;
      ADDR_WIDTH'(OFF_CMP_LO):   rd_data = cmp[31:0];
      ADDR_WIDTH'(OFF_CMP_HI):   rd_data = cmp[63:32];
`ifdef AXIL_TIMER_PRESCALER_EN
      ADDR_WIDTH'(OFF_PRESCALE): rd_data = {16'b0, prescale};
`endif
      default:                   rd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate <= W_IDLE;
      bvalid <= 1'b0;
      bresp  <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (aw_hs) begin
          wstate <= W_RESP;
          bvalid <= 1'b1;
          bresp  <= w_ok ? OKAY : SLVERR;
        end
        W_RESP: if (bready) begin
          wstate <= W_IDLE;
          bvalid <= 1'b0;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // arready is registered so it stays low during reset and rises the cycle after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      shadow  <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (ar_hs) begin
          rstate  <= R_DATA;
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rdata   <= rd_data;
          rresp   <= rd_ok ? OKAY : SLVERR;
          if (ra == ADDR_WIDTH'(OFF_CNT_LO)) shadow <= cnt[63:32];
        end else begin
          arready <= 1'b1;
        end
        R_DATA: if (rready) begin
          rstate  <= R_IDLE;
          rvalid  <= 1'b0;
          arready <= 1'b1;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  axil_timer_core u_core (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .wdata       (wdata),
    .wmask       (wmask),
    .we_ctrl     (we_ctrl),
    .we_status   (we_status),
    .we_cnt_lo   (we_cnt_lo),
    .we_cnt_hi   (we_cnt_hi),
    .we_cmp_lo   (we_cmp_lo),
    .we_cmp_hi   (we_cmp_hi),
    .we_prescale (we_prescale),
    .ctrl        (ctrl),
    .pending     (pending),
    .cnt         (cnt),
    .cmp         (cmp),
    .prescale    (prescale),
    .irq         (irq)
  );

endmodule
